udp_order_parser: RTL and testbench

UDP_ORDER_PARSER -- requirements
Module: udp_order_parser

---
 rtl/udp_order_parser.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_udp_order_parser.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udp_order_parser.sv
// udp_order_parser
//    Parses Ethernet/IPv4/UDP frames arriving one byte per cycle and extracts
//    market orders for a downstream consumer.
//    - Header bytes 0-41 are filtered on the following fields:
//      EtherType 0x0800, protocol UDP, destination IP and UDP source port.
//    - Bytes 42-44 carry a 24-bit opcode.
//    - A market opcode turns each 4 payload bytes into one 32-bit order.
//    - A dump opcode requests a book dump once the frame ends.
//
// Parameters
//    DEST_IP    required IPv4 destination address
//    SRC_PORT   required UDP source port
//    OP_MARKET  market-order opcode
//    OP_DUMP    book-dump opcode
//
// Ports
//    clk_udp         sole clock
//    rst_udp         asynchronous active-high reset
//    rx_axis_tdata   received frame byte
//    rx_axis_tvalid  byte valid (no backpressure)
//    rx_axis_tlast   last byte of frame
//    order_data      {price[15:0], is_buy, is_bot, qty[13:0]}
//    order_valid     order available, held until order_ready
//    order_ready     downstream accepts the order
//    dump_req        one-cycle dump command pulse
//    frame_err       one-cycle malformed-frame pulse
//    order_ovf       one-cycle dropped-order pulse
//
// Optional build macro PARSER_STATS_EN adds saturating 16-bit counters:
//    stat_frames     frames reaching the payload stage or issuing a dump
//    stat_orders     orders delivered by handshake
//    stat_drops      order_ovf plus frame_err pulses
module udp_order_parser #(
   parameter logic [31:0] DEST_IP   = 32'hC0A80132,
   parameter logic [15:0] SRC_PORT  = 16'd55555,
   parameter logic [23:0] OP_MARKET = 24'h102030,
   parameter logic [23:0] OP_DUMP   = 24'hF0E0D0
) (
   input  logic        clk_udp,
   input  logic        rst_udp,
   input  logic [7:0]  rx_axis_tdata,
   input  logic        rx_axis_tvalid,
   input  logic        rx_axis_tlast,
   output logic [31:0] order_data,
   output logic        order_valid,
   input  logic        order_ready,
   output logic        dump_req,
   output logic        frame_err,
   output logic        order_ovf
`ifdef PARSER_STATS_EN
   ,
   output logic [15:0] stat_frames,
   output logic [15:0] stat_orders,
   output logic [15:0] stat_drops
`endif
);

   typedef enum logic [1:0] {
      HDR,
      OPC,
      PAY,
      DROP
   } state_t;

   state_t      state;
   state_t      state_next;

   // Saturates at 63; only indices up to 44 are ever decoded.
   logic [5:0]  byte_idx;
   // Holds the three most recent opcode/payload bytes; together with the
   // incoming byte it forms the full 32-bit big-endian word.
   logic [23:0] shift_reg;
   logic [1:0]  pay_cnt;
   logic        dump_flag;

   logic        hdr_byte_ok;
   logic [23:0] opcode_full;
   logic [31:0] word_full;
   logic        opc_last;
   logic        is_market;
   logic        is_dump;
   logic        word_done;

   logic        frame_err_next;
   logic        dump_req_next;
   logic        order_ovf_next;
   logic        dump_set;
   logic        frame_counted;

   assign opcode_full = {shift_reg[15:0], rx_axis_tdata};
   assign word_full   = {shift_reg, rx_axis_tdata};
   assign opc_last    = (state == OPC) && (byte_idx == 6'd44);
   assign is_market   = (opcode_full == OP_MARKET);
   assign is_dump     = (opcode_full == OP_DUMP);
   assign word_done   = rx_axis_tvalid && (state == PAY) && (pay_cnt == 2'd3);

   // Header filter: only the listed offsets are compared, all others pass.
   always_comb begin
      hdr_byte_ok = 1'b1;
      case (byte_idx)
         6'd12:   hdr_byte_ok = (rx_axis_tdata == 8'h08);
         6'd13:   hdr_byte_ok = (rx_axis_tdata == 8'h00);
         6'd23:   hdr_byte_ok = (rx_axis_tdata == 8'h11);
         6'd30:   hdr_byte_ok = (rx_axis_tdata == DEST_IP[31:24]);
         6'd31:   hdr_byte_ok = (rx_axis_tdata == DEST_IP[23:16]);
         6'd32:   hdr_byte_ok = (rx_axis_tdata == DEST_IP[15:8]);
         6'd33:   hdr_byte_ok = (rx_axis_tdata == DEST_IP[7:0]);
         6'd34:   hdr_byte_ok = (rx_axis_tdata == SRC_PORT[15:8]);
         6'd35:   hdr_byte_ok = (rx_axis_tdata == SRC_PORT[7:0]);
         default: hdr_byte_ok = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_udp or posedge rst_udp) begin
      if (rst_udp) begin
         state <= HDR;
      end else begin
         state <= state_next;
      end
   end

   // ---------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_next = state;
      if (rx_axis_tvalid) begin
         unique case (state)
            HDR: begin
               // A short frame ends here even if this byte also mismatches.
               if (rx_axis_tlast)
                  state_next = HDR;
               else if (!hdr_byte_ok)
                  state_next = DROP;
               else if (byte_idx == 6'd41)
                  state_next = OPC;
            end
            OPC: begin
               if (rx_axis_tlast)
                  state_next = HDR;
               else if (byte_idx == 6'd44)
                  state_next = is_market ? PAY : DROP;
            end
            PAY: begin
               if (rx_axis_tlast)
                  state_next = HDR;
            end
            DROP: begin
               if (rx_axis_tlast)
                  state_next = HDR;
            end
            default: state_next = HDR;
         endcase
      end
   end

   // ---------------------------------------------------------------
   // FSM: output/event decode (registered below as single-cycle pulses)
   // ---------------------------------------------------------------
   always_comb begin
      frame_err_next = 1'b0;
      dump_req_next  = 1'b0;
      dump_set       = 1'b0;
      frame_counted  = 1'b0;
      order_ovf_next = word_done && order_valid && !order_ready;
      if (rx_axis_tvalid) begin
         unique case (state)
            HDR: begin
               frame_err_next = rx_axis_tlast;
            end
            OPC: begin
               frame_err_next = rx_axis_tlast;
               dump_set       = opc_last && !rx_axis_tlast && is_dump;
               frame_counted  = opc_last && !rx_axis_tlast &&
                                (is_market || is_dump);
            end
            PAY: begin
               // A word completing on the tlast byte leaves no partial word.
               frame_err_next = rx_axis_tlast && (pay_cnt != 2'd3);
            end
            DROP: begin
               dump_req_next = rx_axis_tlast && dump_flag;
            end
            default: begin
               frame_err_next = 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------
   // Byte index, shift register, payload counter and dump flag
   // ---------------------------------------------------------------
   always_ff @(posedge clk_udp or posedge rst_udp) begin
      if (rst_udp) begin
         byte_idx  <= '0;
         shift_reg <= '0;
         pay_cnt   <= '0;
         dump_flag <= 1'b0;
      end else if (rx_axis_tvalid) begin
         if (rx_axis_tlast)
            byte_idx <= '0;
         else if (byte_idx != 6'd63)
            byte_idx <= byte_idx + 6'd1;

         if ((state == OPC) || (state == PAY))
            shift_reg <= {shift_reg[15:0], rx_axis_tdata};

         if ((state == PAY) && !rx_axis_tlast)
            pay_cnt <= pay_cnt + 2'd1;
         else
            pay_cnt <= '0;

         if (dump_set)
            dump_flag <= 1'b1;
         else if ((state == DROP) && rx_axis_tlast)
            dump_flag <= 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Event pulses
   // ---------------------------------------------------------------
   always_ff @(posedge clk_udp or posedge rst_udp) begin
      if (rst_udp) begin
         frame_err <= 1'b0;
         dump_req  <= 1'b0;
         order_ovf <= 1'b0;
      end else begin
         frame_err <= frame_err_next;
         dump_req  <= dump_req_next;
         order_ovf <= order_ovf_next;
      end
   end

   // ---------------------------------------------------------------
   // Order output holding register
   // ---------------------------------------------------------------
   always_ff @(posedge clk_udp or posedge rst_udp) begin
      if (rst_udp) begin
         order_data  <= '0;
         order_valid <= 1'b0;
      end else if (order_valid && order_ready) begin
         // Handshake this cycle: a word completing now loads back-to-back.
         if (word_done) begin
            order_data  <= word_full;
            order_valid <= 1'b1;
         end else begin
            order_valid <= 1'b0;
         end
      end else if (!order_valid && word_done) begin
         order_data  <= word_full;
         order_valid <= 1'b1;
      end
   end

`ifdef PARSER_STATS_EN
   // ---------------------------------------------------------------
   // Saturating statistics counters
   // ---------------------------------------------------------------
   always_ff @(posedge clk_udp or posedge rst_udp) begin
      if (rst_udp) begin
         stat_frames <= '0;
         stat_orders <= '0;
         stat_drops  <= '0;
      end else begin
         if (frame_counted && (stat_frames != '1))
            stat_frames <= stat_frames + 16'd1;
         if (order_valid && order_ready && (stat_orders != '1))
            stat_orders <= stat_orders + 16'd1;
         // order_ovf and frame_err cannot pulse in the same cycle.
         if ((order_ovf || frame_err) && (stat_drops != '1))
            stat_drops <= stat_drops + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_udp_order_parser.sv
// tb_udp_order_parser
//    Directed bench for udp_order_parser: each task builds frames, drives
//    them byte by byte and compares outputs against hand-computed values.
module tb_udp_order_parser;

   logic        clk_udp;
   logic        rst_udp;
   logic [7:0]  rx_axis_tdata;
   logic        rx_axis_tvalid;
   logic        rx_axis_tlast;
   logic [31:0] order_data;
   logic        order_valid;
   logic        order_ready;
   logic        dump_req;
   logic        frame_err;
   logic        order_ovf;

   int unsigned n_checks;
   int unsigned n_fail;

   // Monitor-side event counts and delivered words
   int unsigned  n_ovf;
   int unsigned  n_ferr;
   int unsigned  n_dump;
   logic [31:0]  got[$];

   logic [7:0]   frm[$];
   bit           gaps;

   udp_order_parser #(
      .DEST_IP   (32'hC0A80132),
      .SRC_PORT  (16'd55555),
      .OP_MARKET (24'h102030),
      .OP_DUMP   (24'hF0E0D0)
   ) dut (
      .clk_udp        (clk_udp),
      .rst_udp        (rst_udp),
      .rx_axis_tdata  (rx_axis_tdata),
      .rx_axis_tvalid (rx_axis_tvalid),
      .rx_axis_tlast  (rx_axis_tlast),
      .order_data     (order_data),
      .order_valid    (order_valid),
      .order_ready    (order_ready),
      .dump_req       (dump_req),
      .frame_err      (frame_err),
      .order_ovf      (order_ovf)
   );

   initial clk_udp = 1'b0;
   always #5 clk_udp = ~clk_udp;

   always @(negedge clk_udp) begin
      if (!rst_udp) begin
         if (order_valid && order_ready) got.push_back(order_data);
         if (order_ovf) n_ovf++;
         if (frame_err) n_ferr++;
         if (dump_req)  n_dump++;
      end
   end

   // Header with filler 0xA5 in unchecked bytes; b33 is the IP low byte.
   task automatic build_frame(input logic [7:0] b33, input logic [23:0] op);
      logic [7:0] b;
      frm.delete();
      for (int i = 0; i < 42; i++) begin
         case (i)
            12:      b = 8'h08;
            13:      b = 8'h00;
            23:      b = 8'h11;
            30:      b = 8'hC0;
            31:      b = 8'hA8;
            32:      b = 8'h01;
            33:      b = b33;
            34:      b = 8'hD9;
            35:      b = 8'h03;
            default: b = 8'hA5;
         endcase
         frm.push_back(b);
      end
      frm.push_back(op[23:16]);
      frm.push_back(op[15:8]);
      frm.push_back(op[7:0]);
   endtask

   task automatic add_word(input logic [31:0] w);
      frm.push_back(w[31:24]);
      frm.push_back(w[23:16]);
      frm.push_back(w[15:8]);
      frm.push_back(w[7:0]);
   endtask

   task automatic idle(input int unsigned n);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk_udp);
         #1;
      end
   endtask

   // Drives frm[first..last]; returns at posedge+1 after the final byte.
   task automatic send_range(input int unsigned first, input int unsigned last,
                             input bit with_tlast);
      for (int unsigned i = first; i <= last; i++) begin
         rx_axis_tdata  = frm[i];
         rx_axis_tvalid = 1'b1;
         rx_axis_tlast  = with_tlast && (i == last);
         @(posedge clk_udp);
         #1;
         if (gaps && (i != last)) begin
            rx_axis_tvalid = 1'b0;
            rx_axis_tdata  = 8'hEE;
            @(posedge clk_udp);
            #1;
         end
      end
      rx_axis_tvalid = 1'b0;
      rx_axis_tlast  = 1'b0;
   endtask

   task automatic send_frame();
      send_range(0, frm.size() - 1, 1'b1);
   endtask

   task automatic check_outputs_zero(input string tag);
      n_checks++;
      if (order_valid !== 1'b0 || order_data !== 32'h0 || dump_req !== 1'b0 ||
          frame_err !== 1'b0 || order_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: valid=%b data=%h dump=%b ferr=%b ovf=%b, all required 0",
                  tag, order_valid, order_data, dump_req, frame_err, order_ovf);
      end
   endtask

   task automatic test_reset();
      rst_udp = 1'b1;
      idle(2);
      check_outputs_zero("reset_state");
      @(negedge clk_udp);
      rst_udp = 1'b0;
      idle(2);
   endtask

   task automatic test_single_order();
      int unsigned g0, f0;
      g0 = got.size(); f0 = n_ferr;
      order_ready = 1'b1;
      build_frame(8'h32, 24'h102030);
      add_word(32'h0069000A);
      send_frame();
      n_checks++;
      if (order_valid !== 1'b1 || order_data !== 32'h0069000A) begin
         n_fail++;
         $display("FAIL single_latency: valid=%b data=%h, required 1 / 0069000a",
                  order_valid, order_data);
      end
      idle(5);
      n_checks++;
      if (got.size() - g0 != 1) begin
         n_fail++;
         $display("FAIL single_count: delivered %0d, required 1", got.size() - g0);
      end
      n_checks++;
      if (n_ferr != f0) begin
         n_fail++;
         $display("FAIL single_ferr: frame_err pulses %0d, required 0", n_ferr - f0);
      end
   endtask

   task automatic test_overflow();
      int unsigned g0, o0, f0;
      g0 = got.size(); o0 = n_ovf; f0 = n_ferr;
      order_ready = 1'b0;
      build_frame(8'h32, 24'h102030);
      add_word(32'h0064000A);
      add_word(32'h0066000A);
      add_word(32'h006C000A);
      send_frame();
      idle(20);
      n_checks++;
      if (order_valid !== 1'b1 || order_data !== 32'h0064000A) begin
         n_fail++;
         $display("FAIL ovf_held: valid=%b data=%h, required 1 / 0064000a",
                  order_valid, order_data);
      end
      n_checks++;
      if (n_ovf - o0 != 2) begin
         n_fail++;
         $display("FAIL ovf_count: order_ovf pulses %0d, required 2", n_ovf - o0);
      end
      order_ready = 1'b1;
      idle(4);
      n_checks++;
      if (got.size() - g0 != 1 || got[got.size() - 1] !== 32'h0064000A) begin
         n_fail++;
         $display("FAIL ovf_delivered: count %0d last %h, required 1 / 0064000a",
                  got.size() - g0, got[got.size() - 1]);
      end
      n_checks++;
      if (order_valid !== 1'b0 || n_ferr != f0) begin
         n_fail++;
         $display("FAIL ovf_after: valid=%b ferr pulses %0d, required 0 / 0",
                  order_valid, n_ferr - f0);
      end
   endtask

   task automatic test_dump();
      int unsigned g0, f0, d0;
      g0 = got.size(); f0 = n_ferr; d0 = n_dump;
      build_frame(8'h32, 24'hF0E0D0);
      frm.push_back(8'h00);
      send_frame();
      n_checks++;
      if (dump_req !== 1'b1) begin
         n_fail++;
         $display("FAIL dump_latency: dump_req=%b, required 1", dump_req);
      end
      idle(5);
      n_checks++;
      if (n_dump - d0 != 1 || got.size() != g0 || n_ferr != f0) begin
         n_fail++;
         $display("FAIL dump_events: dumps %0d orders %0d ferr %0d, required 1 / 0 / 0",
                  n_dump - d0, got.size() - g0, n_ferr - f0);
      end
   endtask

   task automatic test_bad_ip();
      int unsigned g0, f0;
      g0 = got.size(); f0 = n_ferr;
      build_frame(8'h51, 24'h102030);
      add_word(32'h0069000A);
      send_frame();
      idle(4);
      n_checks++;
      if (got.size() != g0 || n_ferr != f0 || order_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL badip_silent: orders %0d ferr %0d valid %b, required 0 / 0 / 0",
                  got.size() - g0, n_ferr - f0, order_valid);
      end
      // Follow-up frame with idle gaps between bytes: index must hold.
      gaps = 1'b1;
      build_frame(8'h32, 24'h102030);
      add_word(32'h00C8C005);
      send_frame();
      gaps = 1'b0;
      idle(4);
      n_checks++;
      if (got.size() - g0 != 1 || got[got.size() - 1] !== 32'h00C8C005) begin
         n_fail++;
         $display("FAIL badip_next: count %0d last %h, required 1 / 00c8c005",
                  got.size() - g0, got[got.size() - 1]);
      end
   endtask

   task automatic test_partial();
      int unsigned g0, f0;
      g0 = got.size(); f0 = n_ferr;
      build_frame(8'h32, 24'h102030);
      add_word(32'h0065000A);
      frm.push_back(8'h12);
      frm.push_back(8'h34);
      send_frame();
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL partial_ferr: frame_err=%b, required 1", frame_err);
      end
      idle(4);
      n_checks++;
      if (got.size() - g0 != 1 || got[got.size() - 1] !== 32'h0065000A ||
          n_ferr - f0 != 1) begin
         n_fail++;
         $display("FAIL partial_events: orders %0d last %h ferr %0d, required 1 / 0065000a / 1",
                  got.size() - g0, got[got.size() - 1], n_ferr - f0);
      end
   endtask

   task automatic test_mid_reset();
      int unsigned g0, f0;
      build_frame(8'h32, 24'h102030);
      add_word(32'h006A000A);
      send_range(0, 43, 1'b0);
      rst_udp = 1'b1;
      #1;
      check_outputs_zero("midreset_async");
      idle(2);
      check_outputs_zero("midreset_hold");
      @(negedge clk_udp);
      rst_udp = 1'b0;
      idle(1);
      g0 = got.size(); f0 = n_ferr;
      // Tail of the abandoned frame (5 bytes) is now a short frame.
      send_range(44, frm.size() - 1, 1'b1);
      idle(3);
      n_checks++;
      if (got.size() != g0 || n_ferr - f0 != 1) begin
         n_fail++;
         $display("FAIL midreset_tail: orders %0d ferr %0d, required 0 / 1",
                  got.size() - g0, n_ferr - f0);
      end
      build_frame(8'h32, 24'h102030);
      add_word(32'h006E8014);
      send_frame();
      idle(4);
      n_checks++;
      if (got.size() - g0 != 1 || got[got.size() - 1] !== 32'h006E8014) begin
         n_fail++;
         $display("FAIL midreset_clean: count %0d last %h, required 1 / 006e8014",
                  got.size() - g0, got[got.size() - 1]);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned g0;
      g0 = got.size();
      order_ready = 1'b1;
      build_frame(8'h32, 24'h102030);
      add_word(32'h01F40003);
      add_word(32'h01F5C007);
      send_frame();
      idle(4);
      n_checks++;
      if (got.size() - g0 != 2 || got[g0] !== 32'h01F40003 ||
          got[got.size() - 1] !== 32'h01F5C007) begin
         n_fail++;
         $display("FAIL b2b_words: count %0d, required 2 words 01f40003 01f5c007",
                  got.size() - g0);
      end
   endtask

   task automatic test_short_and_unknown();
      int unsigned g0, f0, d0;
      g0 = got.size(); f0 = n_ferr; d0 = n_dump;
      build_frame(8'h32, 24'h102030);
      frm = frm[0:19];
      send_frame();
      n_checks++;
      if (frame_err !== 1'b1) begin
         n_fail++;
         $display("FAIL short_ferr: frame_err=%b, required 1", frame_err);
      end
      build_frame(8'h32, 24'h112233);
      add_word(32'h0069000A);
      send_frame();
      idle(4);
      n_checks++;
      if (got.size() != g0 || n_ferr - f0 != 1 || n_dump != d0) begin
         n_fail++;
         $display("FAIL unknown_op: orders %0d ferr %0d dumps %0d, required 0 / 1 / 0",
                  got.size() - g0, n_ferr - f0, n_dump - d0);
      end
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      n_ovf = 0; n_ferr = 0; n_dump = 0;
      gaps = 1'b0;
      rx_axis_tdata = 8'h00; rx_axis_tvalid = 1'b0; rx_axis_tlast = 1'b0;
      order_ready = 1'b1;
      rst_udp = 1'b1;
      test_reset();
      test_single_order();
      test_overflow();
      test_dump();
      test_bad_ip();
      test_partial();
      test_mid_reset();
      test_back_to_back();
      test_short_and_unknown();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
